// File: rtl/tt_pkg.sv
// ---------------------------------------------------------------------------
// tt_pkg
// Shared definitions for the 8x8 times-table controller and its memory.
//   tt_state_t  : controller states (IDLE, FILL, SERVE)
//   TT_DEPTH    : number of table entries (8 x 8)
//   TT_ADDR_W   : table address width, address = {a, b}
//   TT_OPND_W   : operand width
//   tt_product  : 6-bit product of two 3-bit operands
// ---------------------------------------------------------------------------
package tt_pkg;

    localparam int TT_DEPTH  = 64;
    localparam int TT_ADDR_W = 6;
    localparam int TT_OPND_W = 3;
    localparam int TT_PROD_W = 2 * TT_OPND_W;

    localparam logic [TT_ADDR_W-1:0] TT_LAST_ADDR = TT_ADDR_W'(TT_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SERVE = 2'd2
    } tt_state_t;

    function automatic logic [TT_PROD_W-1:0] tt_product(
        input logic [TT_OPND_W-1:0] a,
        input logic [TT_OPND_W-1:0] b
    );
        return {{TT_OPND_W{1'b0}}, a} * {{TT_OPND_W{1'b0}}, b};
    endfunction

endpackage

// File: rtl/tt_mem.sv
// ---------------------------------------------------------------------------
// tt_mem
// 64 x DATA_W single-port synchronous RAM holding the times table.
// One write port, registered read (1-cycle latency), array not reset.
// Ports:
//   clk        in   clock
//   we_i       in   write enable
//   addr_i     in   shared read/write address
//   wdata_i    in   write data
//   rdata_o    out  read data, mem[addr_i] of the previous cycle
// ---------------------------------------------------------------------------
module tt_mem
    import tt_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [TT_ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    logic [DATA_W-1:0] mem_q [TT_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/times_table_ctrl.sv
// ---------------------------------------------------------------------------
// times_table_ctrl
// Fills an internal 64-entry memory with a*b (a, b in 0..7) on start, then
// shares the memory read port between two valid/ready lookup requesters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    pulse: begin (re)fill
//   busy / done              fill in progress / table complete and valid
//   reqN_valid, reqN_a/b     lookup request and operands (N = 0, 1)
//   reqN_ready               request accepted this cycle (combinational)
//   rspN_valid, rspN_data    one-cycle result strobe, held product
// Configuration macro TT_RR_ARB_EN: defined -> round-robin arbitration,
// undefined -> fixed priority with requester 0 winning contention.
// ---------------------------------------------------------------------------
module times_table_ctrl
    import tt_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 req0_valid,
    input  logic [TT_OPND_W-1:0] req0_a,
    input  logic [TT_OPND_W-1:0] req0_b,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    output logic [DATA_W-1:0]    rsp0_data,
    input  logic                 req1_valid,
    input  logic [TT_OPND_W-1:0] req1_a,
    input  logic [TT_OPND_W-1:0] req1_b,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    output logic [DATA_W-1:0]    rsp1_data
);

    tt_state_t            state_q, state_d;
    logic [TT_ADDR_W-1:0] cnt_q, cnt_d;

    logic                 fill_we;
    logic                 serve_open;

    logic [1:0]           req_valid;
    logic [1:0]           grant;
    logic [1:0]           ready;
    logic                 accept;

    logic [TT_ADDR_W-1:0] rd_addr;
    logic [TT_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;

    // Response steering: a read is in flight and which requester owns it.
    logic                 rsp_pend_q;
    logic                 rsp_id_q;
    logic [1:0]           rsp_valid_w;
    logic [1:0][DATA_W-1:0] rsp_data_w;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == TT_LAST_ADDR) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        fill_we    = 1'b0;
        serve_open = 1'b0;
        case (state_q)
            FILL: begin
                busy    = 1'b1;
                fill_we = 1'b1;
            end
            SERVE: begin
                done       = 1'b1;
                // A start in SERVE takes precedence over any request.
                serve_open = ~start;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign req_valid = {req1_valid, req0_valid};

`ifdef TT_RR_ARB_EN
    // prio_q = 1 means requester 1 wins the next contention.
    logic prio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ready[0];
        end
    end

    assign grant[1] = req_valid[1] & (~req_valid[0] | prio_q);
`else
    assign grant[1] = req_valid[1] & ~req_valid[0];
`endif
    assign grant[0] = req_valid[0] & ~grant[1];

    assign ready      = grant & {2{serve_open}};
    assign accept     = |ready;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    // ------------------------------------------------------------------
    // Memory: fill owns the port in FILL, the granted requester otherwise
    // ------------------------------------------------------------------
    assign rd_addr   = ready[1] ? {req1_a, req1_b} : {req0_a, req0_b};
    assign mem_addr  = fill_we ? cnt_q : rd_addr;
    assign mem_wdata = DATA_W'(tt_product(cnt_q[5:3], cnt_q[2:0]));

    tt_mem #(
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (fill_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            rsp_pend_q <= accept;
            rsp_id_q   <= ready[1];
        end
    end

    // ------------------------------------------------------------------
    // Per-requester response: RAM output is passed straight through on the
    // strobe cycle and captured so it stays stable until the next response.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic [DATA_W-1:0] hold_q;

        assign rsp_valid_w[gi] = rsp_pend_q & (rsp_id_q == 1'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
            end else if (rsp_valid_w[gi]) begin
                hold_q <= mem_rdata;
            end
        end

        assign rsp_data_w[gi] = rsp_valid_w[gi] ? mem_rdata : hold_q;
    end

    assign rsp0_valid = rsp_valid_w[0];
    assign rsp1_valid = rsp_valid_w[1];
    assign rsp0_data  = rsp_data_w[0];
    assign rsp1_data  = rsp_data_w[1];

endmodule

// File: tb/tb_times_table_ctrl.sv
// ---------------------------------------------------------------------------
// tb_times_table_ctrl
// Scoreboard bench for times_table_ctrl: accepted requests push a*b into a
// per-requester queue, responses pop and compare. Arbitration expectations
// follow TT_RR_ARB_EN.
// ---------------------------------------------------------------------------
module tb_times_table_ctrl;

    localparam int DATA_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              req0_valid;
    logic [2:0]        req0_a;
    logic [2:0]        req0_b;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_data;
    logic              req1_valid;
    logic [2:0]        req1_a;
    logic [2:0]        req1_b;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_data;

    int errors = 0;
    int checks = 0;

    int  exp_q0[$];
    int  exp_q1[$];
    bit  acc0_prev = 1'b0;
    bit  acc1_prev = 1'b0;
    int  last0 = 0;
    int  last1 = 0;

    times_table_ctrl #(
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            acc0_prev = 1'b0;
            acc1_prev = 1'b0;
            last0     = 0;
            last1     = 0;
        end else begin
            check_eq("rsp0_valid", int'(rsp0_valid), int'(acc0_prev));
            check_eq("rsp1_valid", int'(rsp1_valid), int'(acc1_prev));
            if (rsp0_valid) begin
                check_eq("sb0_nonempty", int'(exp_q0.size() > 0), 1);
                if (exp_q0.size() > 0) begin
                    last0 = exp_q0.pop_front();
                    check_eq("rsp0_data", int'(rsp0_data), last0);
                end
                $display("rsp0 data=%0d", rsp0_data);
            end else begin
                check_eq("rsp0_hold", int'(rsp0_data), last0);
            end
            if (rsp1_valid) begin
                check_eq("sb1_nonempty", int'(exp_q1.size() > 0), 1);
                if (exp_q1.size() > 0) begin
                    last1 = exp_q1.pop_front();
                    check_eq("rsp1_data", int'(rsp1_data), last1);
                end
                $display("rsp1 data=%0d", rsp1_data);
            end else begin
                check_eq("rsp1_hold", int'(rsp1_data), last1);
            end
            if (busy) begin
                check_eq("rdy_in_fill", int'(req0_ready | req1_ready), 0);
            end
            if (req0_ready | req1_ready) begin
                check_eq("one_grant", int'(req0_ready & req1_ready), 0);
            end
            if (req0_valid && req0_ready) exp_q0.push_back(int'(req0_a) * int'(req0_b));
            if (req1_valid && req1_ready) exp_q1.push_back(int'(req1_a) * int'(req1_b));
            acc0_prev = req0_valid & req0_ready;
            acc1_prev = req1_valid & req1_ready;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts falling edges with busy high after a sampled start.
    task automatic wait_fill(input string tag);
        int n = 0;
        @(negedge clk);
        check_eq({tag, "_done_low"}, int'(done), 0);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_cycles"}, n, 64);
        check_eq({tag, "_done"}, int'(done), 1);
    endtask

    // Presents a request and returns 1ns after the edge that accepted it.
    task automatic send(input int n, input int a, input int b);
        int t = 0;
        if (n == 0) begin
            req0_valid = 1'b1; req0_a = 3'(a); req0_b = 3'(b);
        end else begin
            req1_valid = 1'b1; req1_a = 3'(a); req1_b = 3'(b);
        end
        @(negedge clk);
        while (!((n == 0) ? req0_ready : req1_ready) && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100) check_eq("send_timeout", t, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, e1;
        rst = 1'b1; start = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_rdy0", int'(req0_ready), 0);
        check_eq("rst_rdy1", int'(req1_ready), 0);
        check_eq("rst_rspv0", int'(rsp0_valid), 0);
        check_eq("rst_rspv1", int'(rsp1_valid), 0);
        check_eq("rst_rspd0", int'(rsp0_data), 0);
        check_eq("rst_rspd1", int'(rsp1_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Request held from IDLE through FILL
        req1_valid = 1'b1; req1_a = 3'd2; req1_b = 3'd3;
        @(negedge clk);
        check_eq("idle_rdy1", int'(req1_ready), 0);
        pulse_start();
        wait_fill("fill1");
        check_eq("serve_rdy1", int'(req1_ready), 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;

        // Full sweep on requester 0
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                send(0, a, b);
            end
        end
        req0_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Refill: start and a request in the same cycle
        start = 1'b1;
        req0_valid = 1'b1; req0_a = 3'd3; req0_b = 3'd6;
        @(negedge clk);
        check_eq("refill_rdy0", int'(req0_ready), 0);
        @(posedge clk); #1;
        start = 1'b0;
        req0_valid = 1'b0;
        wait_fill("refill");
        @(posedge clk); #1;
        send(0, 7, 7);
        send(0, 0, 5);
        send(0, 3, 6);
        req0_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset at fill cycle 30
        pulse_start();
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_done", int'(done), 0);
        check_eq("midrst_rspv0", int'(rsp0_valid), 0);
        check_eq("midrst_rspv1", int'(rsp1_valid), 0);
        pulse_start();
        wait_fill("fill2");

        // Contention, both requesters valid for 6 cycles
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 3'd7; req0_b = 3'd6;
        req1_valid = 1'b1; req1_a = 3'd5; req1_b = 3'd5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
`ifdef TT_RR_ARB_EN
            e0 = (i % 2 == 0) ? 1 : 0;
            e1 = (i % 2 == 1) ? 1 : 0;
`else
            e0 = 1;
            e1 = 0;
`endif
            check_eq("cont_rdy0", int'(req0_ready), e0);
            check_eq("cont_rdy1", int'(req1_ready), e1);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("sb0_drained", exp_q0.size(), 0);
        check_eq("sb1_drained", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/times_table_ctrl.md
# times_table_ctrl

Controller for the 8x8 times-table memory. On `start` it sequences a fill of a 64-entry product memory with a*b for a, b in 0..7. It then shares the memory's single read port between two requesters using a valid/ready handshake. It sits between the memory (instantiated inside it) and two independent lookup clients.

## Interface

Parameters:
- `DATA_W`, default 6: product width. Must be ≥ 6, since 7x7 = 49. Upper bits are zero-extended.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse; begins (re)fill of the memory
- `busy`  out  1  high while the fill is in progress
- `done`  out  1  high once the memory holds a complete, valid table
- `req0_valid`  in  1  requester 0 lookup request
- `req0_a`, `req0_b`  in  3 each  requester 0 operands
- `req0_ready`  out  1  requester 0 request accepted this cycle
- `rsp0_valid`  out  1  requester 0 result valid
- `rsp0_data`  out  DATA_W  requester 0 product
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`, `rsp1_valid`, `rsp1_data`: the same set for requester 1

## Operation

- The state machine has three states: IDLE, FILL, SERVE.
- Reset:
  - State goes to IDLE.
  - `busy`, `done`, both `reqN_ready`, both `rspN_valid` and both `rspN_data` are 0.
  - The fill counter is 0.
  - The arbitration pointer is set so that requester 0 wins the first contention.
- IDLE: on `start`, go to FILL with the counter at 0.
- FILL:
  - Each cycle, write address {a,b} = counter[5:3], counter[2:0] with data counter[5:3]*counter[2:0], then increment the counter.
  - After address 63 is written, go to SERVE.
  - `start` is ignored.
  - No requests are accepted.
- SERVE:
  - A `start` pulse restarts the fill: go to FILL, drop `done`, and reset the counter to 0.
  - If `start` and a request arrive in the same cycle, `start` wins and the request is not accepted.
- Handshake:
  - `reqN_ready` is combinational. It is high only in SERVE, with no `start`, when `reqN_valid` is high and requester N holds the grant.
  - At most one request is accepted per cycle.
  - A requester holds `valid`, `a` and `b` stable until it sees `ready`.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that was not granted most recently wins.
  - The pointer updates only on an accepted request.
- Response:
  - `rspN_valid` pulses for exactly one cycle.
  - `rspN_data` = mem[{a,b}] and holds its value until the next response to that requester.
  - There is no response back-pressure.
- Reset during FILL or SERVE:
  - Return to IDLE with `done` = 0.
  - Memory contents are don't-care until the next complete fill.
  - A response in flight is dropped; `rspN_valid` is 0 after reset.

## Timing

- `start` sampled at edge k:
  - `busy` = 1 from edge k to edge k+64.
  - Writes occur on edges k+1 .. k+64.
  - `done` = 1 and `busy` = 0 after edge k+64.
  - Total fill time is 64 cycles.
- Read latency is 1 cycle: a request accepted at edge n gives `rspN_valid` = 1 between edges n+1 and n+2.
- Sustained throughput is one lookup per cycle across both requesters.
- With both requesters continuously valid, grants alternate on every cycle (0,1,0,1,...).

## Configuration

`TT_RR_ARB_EN`:
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority. Requester 0 always wins contention, requester 1 is served only when requester 0 is not valid, and the pointer logic is removed.

## Structure

- Shared package `tt_pkg` holds:
  - state enum `tt_state_t` (IDLE, FILL, SERVE)
  - `TT_DEPTH` = 64
  - `TT_ADDR_W` = 6
  - `TT_OPND_W` = 3
- Sub-module `tt_mem`:
  - 64 x DATA_W single-port synchronous RAM.
  - One write port.
  - Registered read with 1-cycle latency.
  - No reset on the array.
- The controller holds the FSM, fill counter, arbiter, and response steering (a registered requester ID).

## Test plan

- Reset then `start`:
  - `busy` is high for exactly 64 cycles, then `done` = 1.
  - Sweep all 64 {a,b} on req0: every `rsp0_data` equals a*b. Spot checks: 7*7 -> 49, 0*5 -> 0, 3*6 -> 18.
- Request before `done`: `req1_valid` = 1 with a=2, b=3 during IDLE and FILL -> `req1_ready` stays 0 until SERVE, then it is accepted and the response is 6 one cycle later.
- Contention:
  - Both valid for 6 cycles, req0=(7,6) and req1=(5,5).
  - With `TT_RR_ARB_EN`: grants alternate 0,1,0,1,0,1, and each response pair is 42 / 25.
  - Without it: req0 is granted all 6 cycles and `req1_ready` stays 0.
- Refill: `start` in SERVE in the same cycle as req0 valid -> no `req0_ready`, `done` drops, and `busy` is high for 64 cycles; after `done` returns, lookups are correct again.
- Reset mid-fill: `rst` at fill cycle 30 -> the next cycle shows `busy` = 0, `done` = 0 and `rspN_valid` = 0; a fresh `start` completes the fill normally.
